// File: rtl/grant_lock_ctrl_if.sv
// ---------------------------------------------------------------------------
// grant_lock_ctrl_if
// Purpose : groups the request/grant signals of grant_lock_ctrl.
// Signals : req_i       - raw request vector, bit n = port n
//           arb_gnt_i   - combinational grant from the upstream arbiter
//           done_i      - per-port release request
//           gnt_o       - locked one-hot grant
//           gnt_idx_o   - binary index of the current owner (0 when none)
//           gnt_valid_o - high while an owner holds the grant
//           timeout_o   - one-cycle pulse when a hold is forcibly ended
// Modports: master - the requester/arbiter side (drives req/arb/done)
//           slave  - grant_lock_ctrl itself
// ---------------------------------------------------------------------------
interface grant_lock_ctrl_if #(
  parameter int NUM_PORTS = 4
);
  localparam int IDX_W = $clog2(NUM_PORTS);

  logic [NUM_PORTS-1:0] req_i;
  logic [NUM_PORTS-1:0] arb_gnt_i;
  logic [NUM_PORTS-1:0] done_i;
  logic [NUM_PORTS-1:0] gnt_o;
  logic [IDX_W-1:0]     gnt_idx_o;
  logic                 gnt_valid_o;
  logic                 timeout_o;

  modport master (
    output req_i, arb_gnt_i, done_i,
    input  gnt_o, gnt_idx_o, gnt_valid_o, timeout_o
  );

  modport slave (
    input  req_i, arb_gnt_i, done_i,
    output gnt_o, gnt_idx_o, gnt_valid_o, timeout_o
  );
endinterface

// File: rtl/grant_lock_ctrl.sv
// ---------------------------------------------------------------------------
// grant_lock_ctrl
// Purpose : locks the one-hot grant of an upstream fixed-priority arbiter
//           onto a single owner until that owner releases (done or request
//           dropped). After a release the controller spends one RELEASE
//           cycle with no grant, then returns to IDLE where the arbiter is
//           sampled again; the new grant appears one cycle after sampling.
// Ports   : clk_i - clock, all state updates on the rising edge
//           rst_i - asynchronous active-high reset
//           bus   - grant_lock_ctrl_if.slave (req/arb_gnt/done in,
//                   gnt/gnt_idx/gnt_valid/timeout out)
// Params  : NUM_PORTS (>= 2) requesters, MAX_HOLD (>= 2) hold limit.
// Config  : define GNT_TIMEOUT_EN to bound each hold to MAX_HOLD cycles and
//           pulse timeout_o on a forced release. Without it timeout_o is 0
//           and holds are unbounded.
// ---------------------------------------------------------------------------
module grant_lock_ctrl #(
  parameter int NUM_PORTS = 4,
  parameter int MAX_HOLD  = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  grant_lock_ctrl_if.slave   bus
);

  localparam int IDX_W = $clog2(NUM_PORTS);
  localparam logic [NUM_PORTS-1:0] ONE_VEC = NUM_PORTS'(1);

  if (NUM_PORTS < 2) begin : g_bad_ports
    $error("grant_lock_ctrl: NUM_PORTS must be >= 2");
  end
  if (MAX_HOLD < 2) begin : g_bad_hold
    $error("grant_lock_ctrl: MAX_HOLD must be >= 2");
  end

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [NUM_PORTS-1:0] r_gnt;
  logic [NUM_PORTS-1:0] w_gnt_nxt;
  logic [IDX_W-1:0]     r_idx;
  logic [IDX_W-1:0]     w_idx_nxt;
  logic                 r_valid;
  logic                 w_valid_nxt;

  logic                 w_onehot;
  logic                 w_req_match;
  logic                 w_owner_rel;
  logic                 w_expire;

  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [NUM_PORTS-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (oh[i]) idx = idx | IDX_W'(i);
    end
    return idx;
  endfunction

  // x & (x-1) clears the lowest set bit: zero result on a non-zero x means one-hot
  assign w_onehot    = (bus.arb_gnt_i != '0) &&
                       ((bus.arb_gnt_i & (bus.arb_gnt_i - ONE_VEC)) == '0);
  assign w_req_match = |(bus.arb_gnt_i & bus.req_i);
  // Masking with the owner's one-hot makes non-owner done/req bits irrelevant
  assign w_owner_rel = |(r_gnt & (bus.done_i | ~bus.req_i));

`ifdef GNT_TIMEOUT_EN
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  logic [HOLD_W-1:0] r_hold;
  logic              r_timeout;
  logic              w_timeout_nxt;

  // r_hold counts completed GRANT cycles minus one; reaching HOLD_LAST means
  // the current cycle is the MAX_HOLD-th with gnt_valid_o high.
  assign w_expire      = (r_state == ST_GRANT) && (r_hold == HOLD_LAST);
  // A genuine release in the expiry cycle wins: no timeout is reported.
  assign w_timeout_nxt = w_expire && !w_owner_rel;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_hold    <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_timeout_nxt;
      if (r_state != ST_GRANT) begin
        r_hold <= '0;
      end else begin
        r_hold <= r_hold + HOLD_W'(1);
      end
    end
  end

  assign bus.timeout_o = r_timeout;
`else
  assign w_expire      = 1'b0;
  assign bus.timeout_o = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_idx_nxt   = r_idx;
    w_valid_nxt = r_valid;
    case (r_state)
      ST_IDLE: begin
        if (w_onehot && w_req_match) begin
          w_state_nxt = ST_GRANT;
          w_gnt_nxt   = bus.arb_gnt_i;
          w_idx_nxt   = onehot_to_idx(bus.arb_gnt_i);
          w_valid_nxt = 1'b1;
        end
      end
      ST_GRANT: begin
        if (w_owner_rel || w_expire) begin
          w_state_nxt = ST_RELEASE;
          w_gnt_nxt   = '0;
          w_idx_nxt   = '0;
          w_valid_nxt = 1'b0;
        end
      end
      ST_RELEASE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_gnt_nxt   = '0;
        w_idx_nxt   = '0;
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_gnt   <= '0;
      r_idx   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_idx   <= w_idx_nxt;
      r_valid <= w_valid_nxt;
    end
  end

  assign bus.gnt_o       = r_gnt;
  assign bus.gnt_idx_o   = r_idx;
  assign bus.gnt_valid_o = r_valid;

endmodule
